// File: rtl/qam16_demapper_if.sv
// Sample-in / packed-word-out stream bundle for the QAM16 demapper.
// Modport slave is the demapper side; modport master is the source/sink side.
interface qam16_demapper_if;
  logic [31:0] t0_data;
  logic        t0_last;
  logic        t0_valid;
  logic        t0_ready;
  logic [31:0] i_data;
  logic        i_last;
  logic        i_valid;
  logic        i_ready;

  modport slave (
    input  t0_data, t0_last, t0_valid, i_ready,
    output t0_ready, i_data, i_last, i_valid
  );

  modport master (
    output t0_data, t0_last, t0_valid, i_ready,
    input  t0_ready, i_data, i_last, i_valid
  );
endinterface

// File: rtl/qam16_demapper.sv
// Hard-decision QAM16 demapper: slices each I/Q sample to a 4-bit symbol
// and packs eight symbols per 32-bit output word (first symbol in [3:0]).
module qam16_demapper #(
  parameter int SYMS_PER_WORD = 8
) (
  input  logic        clk,
  input  logic        rstf,
  input  logic [14:0] thresh,
  qam16_demapper_if.slave bus
);

  generate
    if (SYMS_PER_WORD != 8) begin : g_bad_param
      $error("qam16_demapper: SYMS_PER_WORD must be 8");
    end
  endgenerate

  typedef enum logic {ST_RST, ST_RUN} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_t0_ready;
  logic        w_accept;
  logic        w_complete;
  logic [3:0]  w_nib;
  logic [31:0] w_acc_next;
  logic [2:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_data;
  logic        r_last;
  logic        r_valid;

  // T is zero-extended and x sign-extended so -T never overflows at thresh=0x7FFF.
  function automatic logic [1:0] slice(input logic [15:0] x, input logic [14:0] th);
    logic signed [16:0] xs;
    logic signed [16:0] ts;
    xs = {x[15], x};
    ts = {2'b00, th};
    if (xs >= ts)            slice = 2'b10;
    else if (xs >= 17'sd0)   slice = 2'b11;
    else if (xs >= -ts)      slice = 2'b01;
    else                     slice = 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstf) r_state <= ST_RST;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_t0_ready   = 1'b0;
    case (r_state)
      ST_RST: w_state_next = ST_RUN;
      ST_RUN: w_t0_ready   = !r_valid || bus.i_ready;
    endcase
  end

  assign w_accept   = bus.t0_valid && w_t0_ready;
  assign w_nib      = {slice(bus.t0_data[31:16], thresh), slice(bus.t0_data[15:0], thresh)};
  assign w_complete = (r_cnt == 3'(SYMS_PER_WORD - 1)) || bus.t0_last;

  genvar gi;
  generate
    for (gi = 0; gi < SYMS_PER_WORD; gi++) begin : g_nib
      assign w_acc_next[4*gi +: 4] = (r_cnt == 3'(gi)) ? w_nib : r_acc[4*gi +: 4];
    end
  endgenerate

  // A completing accept can only happen when the output slot is free or draining,
  // so loading the word here never overwrites an undelivered one.
  always_ff @(posedge clk) begin
    if (!rstf) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (r_valid && bus.i_ready)
        r_valid <= 1'b0;
      if (w_accept) begin
        if (w_complete) begin
          r_data  <= w_acc_next;
          r_last  <= bus.t0_last;
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  assign bus.t0_ready = w_t0_ready;
  assign bus.i_data   = r_data;
  assign bus.i_last   = r_last;
  assign bus.i_valid  = r_valid;

endmodule

// File: tb/tb_qam16_demapper.sv
// Scoreboard bench for qam16_demapper: expected words are queued at each accept
// and compared when the demapper hands a word downstream.
module tb_qam16_demapper;

  logic        clk;
  logic        rstf;
  logic [14:0] thresh;

  qam16_demapper_if bus ();

  qam16_demapper #(.SYMS_PER_WORD(8)) dut (
    .clk    (clk),
    .rstf   (rstf),
    .thresh (thresh),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] sb_q[$];
  logic [31:0] m_acc;
  int          m_cnt;
  bit          rand_rdy;

  // Reference slicer on plain integers.
  function automatic logic [1:0] ref_slice(input logic [15:0] x, input logic [14:0] th);
    int xi;
    int t;
    xi = int'($signed(x));
    t  = int'(th);
    if (xi >= t)       return 2'b10;
    else if (xi >= 0)  return 2'b11;
    else if (xi >= -t) return 2'b01;
    else               return 2'b00;
  endfunction

  // Axis level that slices to a given 2-bit code when thresh = 0x2000.
  function automatic logic [15:0] lvl(input logic [1:0] c);
    case (c)
      2'b10:   return 16'h3000;
      2'b11:   return 16'h1000;
      2'b01:   return 16'hF000;
      default: return 16'hC000;
    endcase
  endfunction

  task automatic model_accept(input logic [15:0] iv, input logic [15:0] qv, input logic lst);
    logic [3:0] nib;
    nib = {ref_slice(qv, thresh), ref_slice(iv, thresh)};
    m_acc[4*m_cnt +: 4] = nib;
    m_cnt++;
    if (m_cnt == 8 || lst) begin
      sb_q.push_back({lst, m_acc});
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] iv, input logic [15:0] qv, input logic lst);
    int  k;
    bit  done;
    done = 0;
    bus.t0_data  = {qv, iv};
    bus.t0_last  = lst;
    bus.t0_valid = 1'b1;
    for (k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.t0_ready) begin
        model_accept(iv, qv, lst);
        done = 1;
      end
      step();
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: t0_ready=%b required 1 within 200 cycles", bus.t0_ready);
    end
    bus.t0_valid = 1'b0;
    bus.t0_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    rand_rdy     = 0;
    bus.i_ready  = 1'b1;
    for (k = 0; k < 100 && sb_q.size() != 0; k++) step();
    step();
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL %s_drain: pending words=%0d required 0", name, sb_q.size());
    else
      n_pass++;
  endtask

  // Output monitor: a handshake is visible at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (rstf && bus.i_valid && bus.i_ready) begin
      logic [32:0] exp_w;
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL out_unexpected: got last=%b data=%08h required no word", bus.i_last, bus.i_data);
      end else begin
        exp_w = sb_q.pop_front();
        if ({bus.i_last, bus.i_data} !== exp_w)
          $display("FAIL out_word: got last=%b data=%08h required last=%b data=%08h",
                   bus.i_last, bus.i_data, exp_w[32], exp_w[31:0]);
        else begin
          n_pass++;
          $display("word last=%b data=%08h", bus.i_last, bus.i_data);
        end
      end
    end
  end

  task automatic test_reset();
    rstf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.i_valid, bus.i_last, bus.i_data, bus.t0_ready} !== 35'd0)
      $display("FAIL reset_state: valid=%b last=%b data=%08h t0_ready=%b required all 0",
               bus.i_valid, bus.i_last, bus.i_data, bus.t0_ready);
    else n_pass++;
    rstf = 1'b1;
    step();
    n_checks++;
    if (bus.t0_ready !== 1'b1) $display("FAIL reset_run: t0_ready=%b required 1", bus.t0_ready);
    else n_pass++;
  endtask

  task automatic test_full_word();
    thresh = 15'h2000;
    for (int i = 0; i < 8; i++) begin
      send(16'h3000, 16'h3000, i == 7);
      n_checks++;
      if (bus.i_valid !== (i == 7))
        $display("FAIL full_latency: sample=%0d i_valid=%b required %b", i, bus.i_valid, i == 7);
      else n_pass++;
    end
    wait_drain("full");
  endtask

  task automatic test_partial_flush();
    thresh = 15'h2000;
    for (int i = 0; i < 3; i++) send(16'h1000, 16'hF000, i == 2);
    send(lvl(2'b10), lvl(2'b10), 1'b1);
    wait_drain("partial");
  endtask

  task automatic test_boundaries();
    logic [15:0] sweep [8];
    sweep = '{16'h2000, 16'h1FFF, 16'h0000, 16'hFFFF, 16'hE000, 16'hDFFF, 16'h8000, 16'h7FFF};
    thresh = 15'h2000;
    for (int i = 0; i < 8; i++) send(sweep[i], 16'h3000, 1'b0);
    thresh = 15'h0000;
    send(16'h0000, 16'h0000, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1);
    thresh = 15'h7FFF;
    send(16'h7FFF, 16'h8000, 1'b1);
    wait_drain("bound");
  endtask

  task automatic test_ordering();
    logic [3:0] n;
    thresh = 15'h2000;
    for (int i = 0; i < 8; i++) begin
      n = 4'(i);
      send(lvl(n[1:0]), lvl(n[3:2]), 1'b0);
    end
    wait_drain("order");
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    thresh      = 15'h2000;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'b0);
    held = sb_q[0][31:0];
    bus.t0_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.t0_data = $urandom;
      @(negedge clk);
      n_checks++;
      if (bus.t0_ready !== 1'b0 || bus.i_valid !== 1'b1 || bus.i_data !== held)
        $display("FAIL stall: cycle=%0d t0_ready=%b valid=%b data=%08h required 0/1/%08h",
                 c, bus.t0_ready, bus.i_valid, bus.i_data, held);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    bus.t0_valid = 1'b0;
    bus.i_ready  = 1'b1;
    rand_rdy     = 1;
    for (int i = 0; i < 64; i++)
      send(16'($urandom), 16'($urandom), (i == 63) || ($urandom_range(0, 7) == 0));
    wait_drain("bp");
  endtask

  task automatic test_reset_mid_word();
    thresh = 15'h2000;
    for (int i = 0; i < 4; i++) send(16'h1000, 16'h1000, 1'b0);
    rstf = 1'b0;
    @(posedge clk);
    #1;
    rstf  = 1'b1;
    m_acc = '0;
    m_cnt = 0;
    n_checks++;
    if (bus.t0_ready !== 1'b0 || bus.i_valid !== 1'b0)
      $display("FAIL midreset_ready: t0_ready=%b valid=%b required 0/0", bus.t0_ready, bus.i_valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) send(16'hFFFF, 16'hFFFF, i == 7);
    n_checks++;
    if (sb_q.size() != 1 || sb_q[0] !== {1'b1, 32'h55555555})
      $display("FAIL midreset_model: queued=%0d required one word 55555555", sb_q.size());
    else n_pass++;
    wait_drain("midreset");
  endtask

  initial begin
    rstf         = 1'b0;
    thresh       = 15'h2000;
    bus.t0_data  = '0;
    bus.t0_last  = 1'b0;
    bus.t0_valid = 1'b0;
    bus.i_ready  = 1'b1;
    rand_rdy     = 0;
    m_acc        = '0;
    m_cnt        = 0;
    test_reset();
    test_full_word();
    test_partial_flush();
    test_boundaries();
    test_ordering();
    test_backpressure();
    test_reset_mid_word();
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
